// File: rtl/rsnn_pkg.sv
// Shared types, constants and helpers for the parametrised RSNN core.
// The state enum, frame length and saturation helper live here so every block uses the same definitions.
package rsnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCUM  = 2'd2,
        UPDATE = 2'd3
    } rsnn_state_t;

    localparam int LEAK_BITS = 3;

    function automatic int cfg_bits(input int n_in, input int n_neu,
                                    input int w_bits, input int v_bits);
        return (n_in * n_neu + n_neu * n_neu) * w_bits + v_bits + LEAK_BITS;
    endfunction

    // Clamp a wide signed value into the signed range of 'bits' bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/rsnn_cfg_loader.sv
// Serial configuration loader: LSB-first shift register with a bit counter,
// an end-of-frame pulse and a sticky "configuration valid" flag.
module rsnn_cfg_loader #(
    parameter int CFG_BITS = 155
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                take,
    input  logic                data_in,
    output logic [CFG_BITS-1:0] cfg,
    output logic                last_bit,
    output logic                end_writing,
    output logic                data_written
);

    localparam int CW = $clog2(CFG_BITS + 1);

    logic [CW-1:0] count;

    assign last_bit = (count == CW'(CFG_BITS - 1));

    // Bits enter at the MSB and shift down, so after a full frame bit k sits at cfg[k].
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg          <= '0;
            count        <= '0;
            end_writing  <= 1'b0;
            data_written <= 1'b0;
        end else if (enable) begin
            end_writing <= 1'b0;
            if (take) begin
                cfg <= {data_in, cfg[CFG_BITS-1:1]};
                if (count == '0)
                    data_written <= 1'b0;
                if (last_bit) begin
                    count        <= '0;
                    end_writing  <= 1'b1;
                    data_written <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rsnn_core_param.sv
// Recurrent spiking network core with N_NEU leaky integrate-and-fire neurons,
// a time-multiplexed synaptic accumulator and a serially loaded configuration.
module rsnn_core_param
    import rsnn_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_NEU  = 3,
    parameter int W_BITS = 8,
    parameter int V_BITS = 8,
    localparam int TW    = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             system_enable,
    input  logic [N_IN-1:0]  input_spikes,
    input  logic             spike_input_reg_enable,
    input  logic             RSNN_enable,
    input  logic             data_in,
    input  logic             load_params,
    input  logic             sel_test,
    input  logic [TW-1:0]    test_idx,
    output logic [N_NEU-1:0] output_spikes,
    output logic             end_writing,
    output logic             data_written,
    output logic             step_done,
    output logic [7:0]       out_test
);

    localparam int N_SRC    = N_IN + N_NEU;
    localparam int CFG_BITS = cfg_bits(N_IN, N_NEU, W_BITS, V_BITS);
    localparam int AW       = V_BITS + W_BITS + $clog2(N_SRC + 1);
    localparam int JW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int OFF_REC  = N_IN * N_NEU * W_BITS;
    localparam int OFF_THR  = (N_IN * N_NEU + N_NEU * N_NEU) * W_BITS;
    localparam int OFF_LEAK = OFF_THR + V_BITS;

    rsnn_state_t state;
    logic [JW-1:0] j;
    logic [N_IN-1:0] in_reg;
    logic signed [V_BITS-1:0] v [N_NEU];
    logic signed [AW-1:0] acc [N_NEU];

    logic [CFG_BITS-1:0] cfg;
    logic last_bit;
    logic load_take;

    // Loader only listens while the FSM is idle or already loading.
    assign load_take = system_enable && load_params && (state == IDLE || state == LOAD);

    rsnn_cfg_loader #(.CFG_BITS(CFG_BITS)) u_loader (
        .clk          (clk),
        .reset        (reset),
        .enable       (system_enable),
        .take         (load_take),
        .data_in      (data_in),
        .cfg          (cfg),
        .last_bit     (last_bit),
        .end_writing  (end_writing),
        .data_written (data_written)
    );

    logic signed [V_BITS-1:0]    thr;
    logic [LEAK_BITS-1:0]        leak_sh;
    logic signed [W_BITS-1:0]    w_all [N_NEU][N_SRC];

    assign thr     = cfg[OFF_THR +: V_BITS];
    assign leak_sh = cfg[OFF_LEAK +: LEAK_BITS];

    // Weights indexed by presynaptic source: inputs first, then recurrent neurons.
    for (genvar gn = 0; gn < N_NEU; gn++) begin : g_neu
        for (genvar gs = 0; gs < N_SRC; gs++) begin : g_src
            if (gs < N_IN) begin : g_in
                assign w_all[gn][gs] = cfg[(gn * N_IN + gs) * W_BITS +: W_BITS];
            end else begin : g_rec
                assign w_all[gn][gs] = cfg[OFF_REC + (gn * N_NEU + gs - N_IN) * W_BITS +: W_BITS];
            end
        end
    end

    logic [N_SRC-1:0] src_vec;
    logic             src_bit;
    assign src_vec = {output_spikes, in_reg};
    assign src_bit = src_vec[j];

    logic signed [AW-1:0]     v_ext  [N_NEU];
    logic signed [AW-1:0]     leaked [N_NEU];
    logic signed [V_BITS-1:0] sat    [N_NEU];

    always_comb begin
        for (int n = 0; n < N_NEU; n++) begin
            v_ext[n]  = AW'(v[n]);
            leaked[n] = v_ext[n] - (v_ext[n] >>> leak_sh);
            sat[n]    = V_BITS'(saturate(64'(acc[n]), V_BITS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            j             <= '0;
            in_reg        <= '0;
            output_spikes <= '0;
            step_done     <= 1'b0;
            for (int n = 0; n < N_NEU; n++) begin
                v[n]   <= '0;
                acc[n] <= '0;
            end
        end else if (system_enable) begin
            step_done <= 1'b0;
            if (spike_input_reg_enable)
                in_reg <= input_spikes;
            case (state)
                IDLE: begin
                    if (load_params) begin
                        state <= LOAD;
                    end else if (RSNN_enable && data_written) begin
                        state <= ACCUM;
                        j     <= '0;
                        for (int n = 0; n < N_NEU; n++)
                            acc[n] <= leaked[n];
                    end
                end
                LOAD: begin
                    if (load_params && last_bit)
                        state <= IDLE;
                end
                ACCUM: begin
                    if (src_bit) begin
                        for (int n = 0; n < N_NEU; n++)
                            acc[n] <= acc[n] + AW'(w_all[n][j]);
                    end
                    if (j == JW'(N_SRC - 1))
                        state <= UPDATE;
                    else
                        j <= j + JW'(1);
                end
                UPDATE: begin
                    for (int n = 0; n < N_NEU; n++) begin
                        if (sat[n] >= thr) begin
                            output_spikes[n] <= 1'b1;
                            v[n]             <= '0;
                        end else begin
                            output_spikes[n] <= 1'b0;
                            v[n]             <= sat[n];
                        end
                    end
                    step_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic signed [V_BITS-1:0] v_sel;
    logic [7:0]               v_byte;

    always_comb begin
        v_sel = '0;
        for (int n = 0; n < N_NEU; n++) begin
            if (test_idx == TW'(n))
                v_sel = v[n];
        end
    end

    if (V_BITS >= 8) begin : g_vbyte_trunc
        assign v_byte = v_sel[7:0];
    end else begin : g_vbyte_sext
        assign v_byte = {{(8 - V_BITS){v_sel[V_BITS-1]}}, v_sel};
    end

    assign out_test = sel_test ? v_byte : {5'd0, data_written, state};

endmodule

// File: doc/rsnn_core_param.md
# rsnn_core_param

Parametrised recurrent spiking neural network core with leaky integrate-and-fire (LIF) neurons. It generalises the fixed 3-input / 3-neuron RSNN top to N_IN inputs and N_NEU neurons, with configurable weight and membrane widths, a programmable leak and a time-multiplexed synaptic accumulator. Parameters (weights, threshold, leak) load over a 1-bit serial port, so the core still fits the TinyTapeout pin budget. It sits directly under the chip wrapper and replaces the fixed RSNN top.

## Interface
- N_IN, default 3: number of external input spike lines.
- N_NEU, default 3: number of neurons; each is also a recurrent source.
- W_BITS, default 8: signed synaptic weight width.
- V_BITS, default 8: signed membrane potential and threshold width.
- CFG_BITS, derived = (N_IN*N_NEU + N_NEU*N_NEU)*W_BITS + V_BITS + 3: serial frame length (155 at defaults).
- clk  in  1: single clock, all logic on the rising edge.
- reset  in  1: synchronous, active-high; clears all state, including the configuration.
- system_enable  in  1: when low, every register holds its value.
- input_spikes  in  N_IN: raw input spikes.
- spike_input_reg_enable  in  1: latches input_spikes into the input register.
- RSNN_enable  in  1: requests one network timestep.
- data_in  in  1: serial configuration bit.
- load_params  in  1: qualifies data_in; one bit is taken per enabled cycle.
- sel_test  in  1: selects the out_test source.
- test_idx  in  $clog2(N_NEU): neuron observed on out_test.
- output_spikes  out  N_NEU: registered neuron spikes from the last timestep.
- end_writing  out  1: one-cycle pulse when the last frame bit is taken.
- data_written  out  1: sticky; high while a complete, valid configuration is held.
- step_done  out  1: one-cycle pulse at the end of each timestep.
- out_test  out  8: debug observation byte.

## Operation
- Frame layout, LSB-first (frame bit k arrives on the k-th accepted load cycle):
  - W_in[n][i] at index n*N_IN+i, W_BITS each.
  - Then W_rec[n][j] at index n*N_NEU+j.
  - Then thr (V_BITS, signed).
  - Then leak_sh (3 bits, unsigned).
- FSM states: IDLE, LOAD, ACCUM, UPDATE.
  - IDLE + load_params → LOAD. Taking bit 0 clears data_written.
  - LOAD: bit count increments only on cycles with load_params high; a gap holds the count. On bit CFG_BITS-1: end_writing pulse, data_written=1, → IDLE.
  - IDLE + RSNN_enable + data_written → ACCUM with j=0; acc[n]=v[n]-(v[n]>>>leak_sh) for every n. RSNN_enable is ignored while data_written=0.
  - ACCUM: one presynaptic source per cycle, j=0..N_IN+N_NEU-1. Sources j<N_IN are in_reg[j] with W_in; the rest are output_spikes[j-N_IN] with W_rec. When the source is 1, acc[n]+=weight for all n in parallel. After the last j → UPDATE.
  - UPDATE: sat=saturate(acc[n]) to V_BITS signed. If sat>=thr: spike[n]=1 and v[n]=0. Otherwise spike[n]=0 and v[n]=sat. output_spikes is updated, step_done pulses, → IDLE.
- Accumulator width is V_BITS+W_BITS+$clog2(N_IN+N_NEU+1). Saturation happens only in UPDATE, clamping to the range -2^(V_BITS-1)..2^(V_BITS-1)-1.
- in_reg loads on spike_input_reg_enable in any state. ACCUM samples in_reg live.
- load_params is ignored in ACCUM and UPDATE. RSNN_enable is ignored in LOAD, ACCUM and UPDATE; it is not queued.
- Simultaneous load_params and RSNN_enable in IDLE: load wins.
- out_test selection:
  - sel_test=1: low 8 bits of v[test_idx], sign-extended if V_BITS<8.
  - sel_test=0: the FSM state code in [1:0] and data_written in [2], upper bits 0.

## Timing
- Reset values: all v, acc, in_reg, weights, thr and leak_sh = 0; state=IDLE; every output = 0.
- Load takes CFG_BITS enabled cycles. end_writing and data_written rise in the cycle after the last bit is sampled.
- Timestep latency from the RSNN_enable sample to step_done high is N_IN+N_NEU+1 cycles (7 at defaults). output_spikes changes in the same cycle as step_done.
- Recurrent inputs always use the spikes of the previous timestep.
- system_enable low freezes the FSM mid-step with no lost or extra bits or sources.
- Reset mid-load or mid-step aborts the operation; the next step needs a full reload.

## Structure
- Package rsnn_pkg holds:
  - The state enum (IDLE/LOAD/ACCUM/UPDATE).
  - The CFG_BITS function.
  - The leak-shift width constant (3).
  - The saturate function.
- One sub-module, rsnn_cfg_loader: serial shift register, bit counter, end_writing/data_written generation, exposing a flat configuration vector.

## Test plan
- Reset and load: assert reset, then shift a 155-bit frame with load_params gaps of 1-3 cycles → end_writing pulses exactly once, data_written=1, and read-back over out_test matches.
- Integrate to threshold: W_in[0][0]=40, thr=100, leak_sh=7, in_reg=3'b001, three steps → output_spikes[0] reads 0, 0, 1 and v[0] returns to 0.
- Leak: v[0]=64 with no input, leak_sh=1 → v[0]=32, then 16; step_done pulses 7 cycles after each RSNN_enable.
- Recurrence: W_rec[1][0]=127, thr=100 → neuron 0 spiking at step t makes neuron 1 spike at step t+1, never at t.
- Saturation: all weights -128 with all inputs and spikes active → v holds -128 with no wrap; all +127 with thr=127 → spike.
- Guards: RSNN_enable before data_written=1 → no step_done. load_params during ACCUM → ignored. system_enable low for 5 cycles mid-step → step_done is delayed by exactly 5 cycles.
